// File: rtl/hazard_ctrl_param_if.sv
// rtl/hazard_ctrl_param_if.sv - pipeline hazard controller signal bundle
interface hazard_ctrl_param_if #(
    parameter int REG_W = 7,
    parameter int CNT_W = 32
);
    logic             exc_flush;
    logic             exc_stall;
    logic             if_stall;
    logic             mem_stall;
    logic             alu_busy;
    logic             alu_done;
    logic             branch_d;
    logic [REG_W-1:0] rs_d;
    logic [REG_W-1:0] rt_d;
    logic [REG_W-1:0] rs_e;
    logic [REG_W-1:0] rt_e;
    logic [REG_W-1:0] wreg_e;
    logic [REG_W-1:0] wreg_m;
    logic [REG_W-1:0] wreg_w;
    logic             regwrite_e;
    logic             regwrite_m;
    logic             regwrite_w;
    logic             memread_e;
    logic             memread_m;
    logic [4:0]       stall;
    logic [4:0]       flush;
    logic [1:0]       fwd_a_d;
    logic [1:0]       fwd_b_d;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output exc_flush, exc_stall, if_stall, mem_stall, alu_busy, alu_done, branch_d,
        output rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
        output regwrite_e, regwrite_m, regwrite_w, memread_e, memread_m,
        input  stall, flush, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_cycles
    );

    modport slave (
        input  exc_flush, exc_stall, if_stall, mem_stall, alu_busy, alu_done, branch_d,
        input  rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
        input  regwrite_e, regwrite_m, regwrite_w, memread_e, memread_m,
        output stall, flush, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_param.sv
// rtl/hazard_ctrl_param.sv - 5-stage MIPS forwarding, hazard and stall arbitration
module hazard_ctrl_param #(
    parameter int REG_W     = 7,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    hazard_ctrl_param_if.slave  hz
);
    typedef enum logic [2:0] {
        ST_RUN, ST_EXCF, ST_EXCS, ST_MEMW, ST_ALUB, ST_DRAIN, ST_HAZ, ST_IFW
    } state_e;

    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYC);

    state_e           state;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic             alu_prev_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [4:0]       stall_sel, flush_sel;
    logic             haz;

    function automatic logic hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst,
                                 input logic we);
        return (src != '0) && we && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] src);
        if (hit(src, hz.wreg_m, hz.regwrite_m) && !hz.memread_m) return 2'b10;
        if (hit(src, hz.wreg_w, hz.regwrite_w))                  return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_d(input logic [REG_W-1:0] src);
        if (hit(src, hz.wreg_e, hz.regwrite_e) && !hz.memread_e) return 2'b01;
        if (hit(src, hz.wreg_m, hz.regwrite_m) && !hz.memread_m) return 2'b10;
        if (hit(src, hz.wreg_w, hz.regwrite_w))                  return 2'b11;
        return 2'b00;
    endfunction

    always_comb begin
        logic e_hit, m_hit;
        e_hit = hit(hz.rs_d, hz.wreg_e, hz.regwrite_e) || hit(hz.rt_d, hz.wreg_e, hz.regwrite_e);
        m_hit = hit(hz.rs_d, hz.wreg_m, hz.regwrite_m) || hit(hz.rt_d, hz.wreg_m, hz.regwrite_m);
        haz   = (hz.memread_e && e_hit) || (hz.branch_d && (e_hit || (hz.memread_m && m_hit)));
    end

    always_comb begin
        state = ST_RUN;
        if      (hz.exc_flush)                 state = ST_EXCF;
        else if (hz.exc_stall)                 state = ST_EXCS;
        else if (hz.mem_stall)                 state = ST_MEMW;
        else if (hz.alu_busy && !hz.alu_done)  state = ST_ALUB;
        else if (drain_cnt_q != 4'd0)          state = ST_DRAIN;
        else if (haz)                          state = ST_HAZ;
        else if (hz.if_stall)                  state = ST_IFW;
    end

    always_comb begin
        stall_sel = 5'b00000;
        flush_sel = 5'b00000;
        unique case (state)
            ST_EXCF:  flush_sel = 5'b01110;
            ST_EXCS:  stall_sel = 5'b11111;
            ST_MEMW:  begin stall_sel = 5'b11110; flush_sel = 5'b00001; end
            ST_ALUB:  begin stall_sel = 5'b11100; flush_sel = 5'b00010; end
            ST_DRAIN: begin stall_sel = 5'b11000; flush_sel = 5'b00100; end
            ST_HAZ:   begin stall_sel = 5'b11000; flush_sel = 5'b00100; end
            ST_IFW:   begin stall_sel = 5'b10000; flush_sel = 5'b01000; end
            default:  ;
        endcase
    end

    // Leaving ALUB into anything but an exception arms the drain window.
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (state == ST_EXCF)
            drain_cnt_d = 4'd0;
        else if (alu_prev_q && state != ST_ALUB && state != ST_EXCS)
            drain_cnt_d = DRAIN_LD;
        else if (state == ST_DRAIN)
            drain_cnt_d = drain_cnt_q - 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_cnt_q    <= 4'd0;
            alu_prev_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            alu_prev_q  <= (state == ST_ALUB);
            if (stall_sel != 5'b00000 && stall_cycles_q != '1)
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    assign hz.stall        = rst_ni ? stall_sel : 5'b00000;
    assign hz.flush        = rst_ni ? flush_sel : 5'b00000;
    assign hz.fwd_a_d      = rst_ni ? fwd_d(hz.rs_d) : 2'b00;
    assign hz.fwd_b_d      = rst_ni ? fwd_d(hz.rt_d) : 2'b00;
    assign hz.fwd_a_e      = rst_ni ? fwd_e(hz.rs_e) : 2'b00;
    assign hz.fwd_b_e      = rst_ni ? fwd_e(hz.rt_e) : 2'b00;
    assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb/tb_hazard_ctrl_param.sv - self-checking bench for hazard_ctrl_param
module tb_hazard_ctrl_param;
    localparam int REG_W = 7;
    localparam int CNT_W = 6;
    localparam int DC    = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [4:0] ST_TAB [8] = '{5'b00000, 5'b00000, 5'b11111, 5'b11110,
                                          5'b11100, 5'b11000, 5'b11000, 5'b10000};
    localparam logic [4:0] FL_TAB [8] = '{5'b00000, 5'b01110, 5'b00000, 5'b00001,
                                          5'b00010, 5'b00100, 5'b00100, 5'b01000};
    localparam int RUN = 0, EXCF = 1, EXCS = 2, MEMW = 3, ALUB = 4, DRAIN = 5, HAZ = 6, IFW = 7;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    int dr, dr0, cnt;
    bit ap, ap0;

    hazard_ctrl_param_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif  ();
    hazard_ctrl_param_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif0 ();

    hazard_ctrl_param #(.REG_W(REG_W), .DRAIN_CYC(DC), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .hz(hif.slave));
    hazard_ctrl_param #(.REG_W(REG_W), .DRAIN_CYC(0), .CNT_W(CNT_W)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .hz(hif0.slave));

    always #5 clk = ~clk;

    assign hif0.exc_flush  = hif.exc_flush;
    assign hif0.exc_stall  = hif.exc_stall;
    assign hif0.if_stall   = hif.if_stall;
    assign hif0.mem_stall  = hif.mem_stall;
    assign hif0.alu_busy   = hif.alu_busy;
    assign hif0.alu_done   = hif.alu_done;
    assign hif0.branch_d   = hif.branch_d;
    assign hif0.rs_d       = hif.rs_d;
    assign hif0.rt_d       = hif.rt_d;
    assign hif0.rs_e       = hif.rs_e;
    assign hif0.rt_e       = hif.rt_e;
    assign hif0.wreg_e     = hif.wreg_e;
    assign hif0.wreg_m     = hif.wreg_m;
    assign hif0.wreg_w     = hif.wreg_w;
    assign hif0.regwrite_e = hif.regwrite_e;
    assign hif0.regwrite_m = hif.regwrite_m;
    assign hif0.regwrite_w = hif.regwrite_w;
    assign hif0.memread_e  = hif.memread_e;
    assign hif0.memread_m  = hif.memread_m;

    function automatic bit m(input logic [REG_W-1:0] s, input logic [REG_W-1:0] d, input logic we);
        return (s != 0) && (we == 1'b1) && (s == d);
    endfunction

    function automatic logic [1:0] exp_fe(input logic [REG_W-1:0] s);
        if (m(s, hif.wreg_m, hif.regwrite_m) && !hif.memread_m) return 2'd2;
        return m(s, hif.wreg_w, hif.regwrite_w) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] exp_fd(input logic [REG_W-1:0] s);
        if (m(s, hif.wreg_e, hif.regwrite_e) && !hif.memread_e) return 2'd1;
        if (m(s, hif.wreg_m, hif.regwrite_m) && !hif.memread_m) return 2'd2;
        return m(s, hif.wreg_w, hif.regwrite_w) ? 2'd3 : 2'd0;
    endfunction

    function automatic int pick(input int drain);
        bit e, mm, h;
        e  = m(hif.rs_d, hif.wreg_e, hif.regwrite_e) || m(hif.rt_d, hif.wreg_e, hif.regwrite_e);
        mm = m(hif.rs_d, hif.wreg_m, hif.regwrite_m) || m(hif.rt_d, hif.wreg_m, hif.regwrite_m);
        h  = (hif.memread_e && e) || (hif.branch_d && (e || (hif.memread_m && mm)));
        if (hif.exc_flush) return EXCF;
        if (hif.exc_stall) return EXCS;
        if (hif.mem_stall) return MEMW;
        if (hif.alu_busy && !hif.alu_done) return ALUB;
        if (drain > 0) return DRAIN;
        if (h) return HAZ;
        if (hif.if_stall) return IFW;
        return RUN;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dr = 0; dr0 = 0; ap = 0; ap0 = 0; cnt = 0;
    endtask

    task automatic next_drain(input int s, input int load, inout int d, inout bit a);
        if (s == EXCF)                          d = 0;
        else if (a && s != ALUB && s != EXCS)   d = load;
        else if (s == DRAIN)                    d = d - 1;
        a = (s == ALUB);
    endtask

    task automatic tick();
        int s, s0;
        @(negedge clk);
        s  = rst_n ? pick(dr)  : RUN;
        s0 = rst_n ? pick(dr0) : RUN;
        chk("stall",   32'(hif.stall),   32'(rst_n ? ST_TAB[s] : 5'b0));
        chk("flush",   32'(hif.flush),   32'(rst_n ? FL_TAB[s] : 5'b0));
        chk("fwd_a_d", 32'(hif.fwd_a_d), 32'(rst_n ? exp_fd(hif.rs_d) : 2'd0));
        chk("fwd_b_d", 32'(hif.fwd_b_d), 32'(rst_n ? exp_fd(hif.rt_d) : 2'd0));
        chk("fwd_a_e", 32'(hif.fwd_a_e), 32'(rst_n ? exp_fe(hif.rs_e) : 2'd0));
        chk("fwd_b_e", 32'(hif.fwd_b_e), 32'(rst_n ? exp_fe(hif.rt_e) : 2'd0));
        chk("stall_cycles", 32'(hif.stall_cycles), 32'(cnt));
        chk("stall_nodrain", 32'(hif0.stall), 32'(rst_n ? ST_TAB[s0] : 5'b0));
        chk("flush_nodrain", 32'(hif0.flush), 32'(rst_n ? FL_TAB[s0] : 5'b0));
        @(posedge clk);
        if (rst_n) begin
            if (ST_TAB[s] != 0 && cnt < CMAX) cnt++;
            next_drain(s, DC, dr, ap);
            next_drain(s0, 0, dr0, ap0);
        end
        #1;
    endtask

    task automatic drive_all(input logic v);
        hif.exc_flush = v; hif.exc_stall = v; hif.if_stall = v; hif.mem_stall = v;
        hif.alu_busy = v; hif.alu_done = v; hif.branch_d = v;
        hif.rs_d = {REG_W{v}}; hif.rt_d = {REG_W{v}}; hif.rs_e = {REG_W{v}}; hif.rt_e = {REG_W{v}};
        hif.wreg_e = {REG_W{v}}; hif.wreg_m = {REG_W{v}}; hif.wreg_w = {REG_W{v}};
        hif.regwrite_e = v; hif.regwrite_m = v; hif.regwrite_w = v;
        hif.memread_e = v; hif.memread_m = v;
    endtask

    task automatic randomize_inputs();
        hif.exc_flush  = ($urandom_range(0, 15) == 0);
        hif.exc_stall  = ($urandom_range(0, 15) == 0);
        hif.mem_stall  = ($urandom_range(0, 7) == 0);
        hif.if_stall   = ($urandom_range(0, 3) == 0);
        hif.alu_busy   = ($urandom_range(0, 2) == 0);
        hif.alu_done   = ($urandom_range(0, 3) == 0);
        hif.branch_d   = ($urandom_range(0, 1) == 0);
        hif.rs_d = 7'($urandom_range(0, 3)); hif.rt_d = 7'($urandom_range(0, 3));
        hif.rs_e = 7'($urandom_range(0, 3)); hif.rt_e = 7'($urandom_range(0, 3));
        hif.wreg_e = 7'($urandom_range(0, 3)); hif.wreg_m = 7'($urandom_range(0, 3));
        hif.wreg_w = 7'($urandom_range(0, 3));
        hif.regwrite_e = ($urandom_range(0, 1) == 0);
        hif.regwrite_m = ($urandom_range(0, 1) == 0);
        hif.regwrite_w = ($urandom_range(0, 1) == 0);
        hif.memread_e  = ($urandom_range(0, 1) == 0);
        hif.memread_m  = ($urandom_range(0, 1) == 0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive_all(1'b1);
        tick(); tick();
        rst_n = 1'b1; drive_all(1'b0);
        tick();
        // forwarding into E
        hif.rs_e = 7'd5; hif.wreg_m = 7'd5; hif.wreg_w = 7'd5;
        hif.regwrite_m = 1'b1; hif.regwrite_w = 1'b1;
        tick();
        hif.memread_m = 1'b1; tick();
        hif.rs_e = 7'd0; tick();
        drive_all(1'b0);
        // load-use bubble
        hif.memread_e = 1'b1; hif.wreg_e = 7'd8; hif.rt_d = 7'd8; hif.regwrite_e = 1'b1;
        tick();
        drive_all(1'b0); tick();
        // branch operand hazards
        hif.branch_d = 1'b1; hif.rs_d = 7'd3; hif.wreg_e = 7'd3; hif.regwrite_e = 1'b1;
        tick();
        hif.regwrite_e = 1'b0; hif.wreg_m = 7'd3; hif.regwrite_m = 1'b1; hif.memread_m = 1'b1;
        tick();
        hif.memread_m = 1'b0; tick();
        drive_all(1'b0);
        // mul/div with drain, then drain aborted by exception flush
        hif.alu_busy = 1'b1; tick(); tick(); tick();
        hif.alu_done = 1'b1; tick();
        drive_all(1'b0); repeat (4) tick();
        hif.alu_busy = 1'b1; tick(); tick(); tick();
        hif.alu_done = 1'b1; tick();
        drive_all(1'b0); tick();
        hif.exc_flush = 1'b1; tick();
        hif.exc_flush = 1'b0; tick(); tick();
        // priority
        hif.exc_flush = 1'b1; hif.mem_stall = 1'b1; hif.if_stall = 1'b1; tick();
        hif.exc_flush = 1'b0; tick();
        hif.mem_stall = 1'b0; tick();
        drive_all(1'b0);
        // reset asserted mid-drain
        hif.alu_busy = 1'b1; tick();
        hif.alu_done = 1'b1; tick();
        drive_all(1'b0); tick();
        rst_n = 1'b0; model_reset(); tick();
        rst_n = 1'b1; tick(); tick();
        // random traffic
        repeat (400) begin
            randomize_inputs();
            tick();
        end
        // counter saturation
        drive_all(1'b0); hif.exc_stall = 1'b1;
        repeat (2 * CMAX) tick();
        chk("stall_cycles_sat", 32'(hif.stall_cycles), 32'(CMAX));
        drive_all(1'b0); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
